bcd_to_fixed_seq: RTL and testbench

Sequential, parametrised BCD-to-fixed-point converter for the calculator datapath front end.
- Takes INT_DIGITS integer BCD digits and FRAC_DIGITS fractional BCD digits.
- Produces an unsigned Q(INT_BITS.FRAC_BITS) value using digit-serial accumulation and a restoring division for the fraction.
- Result rounding is selectable, and digit and overflow errors are flagged.
- Uses valid/ready handshakes on both input and output so it can sit between the keypad/entry logic and the arithmetic unit.

---
 rtl/bcd_to_fixed_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_bcd_to_fixed_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_fixed_seq.sv
// Digit-serial BCD to unsigned Q(INT_BITS.FRAC_BITS) converter with valid/ready
// handshakes; the fraction is produced by restoring division by 10^FRAC_DIGITS.
module bcd_to_fixed_seq #(
    parameter int INT_DIGITS  = 2,
    parameter int FRAC_DIGITS = 2,
    parameter int INT_BITS    = 4,
    parameter int FRAC_BITS   = 6,
    parameter int ROUND       = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [4*INT_DIGITS-1:0]       int_bcd,
    input  logic [4*FRAC_DIGITS-1:0]      frac_bcd,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [INT_BITS+FRAC_BITS-1:0] out_num,
    output logic                          digit_err,
    output logic                          ovf
);
    localparam int IW     = 4 * INT_DIGITS;
    localparam int FW     = 4 * FRAC_DIGITS;
    localparam int AW     = INT_BITS + 4;
    localparam int OW     = INT_BITS + FRAC_BITS;
    localparam int C_MAXC = (INT_DIGITS > FRAC_DIGITS) ?
                            ((INT_DIGITS > FRAC_BITS + 1) ? INT_DIGITS : FRAC_BITS + 1) :
                            ((FRAC_DIGITS > FRAC_BITS + 1) ? FRAC_DIGITS : FRAC_BITS + 1);
    localparam int CW     = $clog2(C_MAXC + 1);

    function automatic logic [FW:0] pow10(input int n);
        logic [FW:0] p;
        p = (FW+1)'(1);
        for (int i = 0; i < n; i++) begin
            p = p * (FW+1)'(10);
        end
        return p;
    endfunction

    localparam logic [FW:0]   C_DEN       = pow10(FRAC_DIGITS);
    localparam logic [CW-1:0] C_INT_LAST  = CW'(INT_DIGITS - 1);
    localparam logic [CW-1:0] C_FRAC_LAST = CW'(FRAC_DIGITS - 1);
    localparam logic [CW-1:0] C_DIV_LAST  = CW'(FRAC_BITS);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INT_ACC  = 3'd1,
        S_FRAC_ACC = 3'd2,
        S_DIV      = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CW-1:0]      r_cnt;
    logic [IW-1:0]      r_int_sh;
    logic [FW-1:0]      r_frac_sh;
    logic [AW-1:0]      r_acc;
    logic [FW-1:0]      r_f;
    logic [FW:0]        r_rem;
    logic [FRAC_BITS-1:0] r_q;
    logic               r_ovf_st;
    logic               r_derr_st;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [OW-1:0]      r_out_num;
    logic               r_digit_err;
    logic               r_ovf;

    logic               w_accept;
    logic [3:0]         w_dig_int;
    logic [3:0]         w_dig_frac;
    logic [AW-1:0]      w_acc_next;
    logic               w_acc_ovf;
    logic [FW-1:0]      w_f_next;
    logic [FW:0]        w_rem_dbl;
    logic               w_ge;
    logic [FW:0]        w_rem_next;
    logic               w_rnd;
    logic [OW:0]        w_sum;
    logic [OW-1:0]      w_res_num;
    logic               w_res_ovf;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_num   = r_out_num;
    assign digit_err = r_digit_err;
    assign ovf       = r_ovf;

    // Per-digit arithmetic, division step and final result composition.
    always_comb begin
        w_accept   = (r_state == S_IDLE) & in_valid & r_in_ready;
        w_dig_int  = r_int_sh[IW-1 -: 4];
        w_dig_frac = r_frac_sh[FW-1 -: 4];
        w_acc_next = r_acc * AW'(10) + AW'(w_dig_int);
        w_acc_ovf  = |w_acc_next[AW-1:INT_BITS];
        w_f_next   = r_f * FW'(10) + FW'(w_dig_frac);
        w_rem_dbl  = r_rem << 1;
        w_ge       = (w_rem_dbl >= C_DEN);
        if (w_ge) begin
            w_rem_next = w_rem_dbl - C_DEN;
        end else begin
            w_rem_next = w_rem_dbl;
        end
        // On the last division step w_ge is the round bit and r_q already holds q.
        if (ROUND != 0) begin
            w_rnd = w_ge;
        end else begin
            w_rnd = 1'b0;
        end
        w_sum = {1'b0, r_acc[INT_BITS-1:0], r_q} + (OW+1)'(w_rnd);
        if (r_derr_st) begin
            w_res_num = '0;
            w_res_ovf = 1'b0;
        end else if (r_ovf_st || w_sum[OW]) begin
            w_res_num = '1;
            w_res_ovf = 1'b1;
        end else begin
            w_res_num = w_sum[OW-1:0];
            w_res_ovf = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_next = S_INT_ACC;
                else          w_state_next = S_IDLE;
            end
            S_INT_ACC: begin
                if (r_cnt == C_INT_LAST) w_state_next = S_FRAC_ACC;
                else                     w_state_next = S_INT_ACC;
            end
            S_FRAC_ACC: begin
                if (r_cnt == C_FRAC_LAST) w_state_next = S_DIV;
                else                      w_state_next = S_FRAC_ACC;
            end
            S_DIV: begin
                if (r_cnt == C_DIV_LAST) w_state_next = S_DONE;
                else                     w_state_next = S_DIV;
            end
            S_DONE: begin
                if (out_ready) w_state_next = S_IDLE;
                else           w_state_next = S_DONE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register, step counter and registered in_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= (w_state_next != r_state) ? '0 : r_cnt + CW'(1);
            r_in_ready <= (w_state_next == S_IDLE);
        end
    end

    // Datapath registers and result/flag outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_int_sh    <= '0;
            r_frac_sh   <= '0;
            r_acc       <= '0;
            r_f         <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_ovf_st    <= 1'b0;
            r_derr_st   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_num   <= '0;
            r_digit_err <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_int_sh  <= int_bcd;
                        r_frac_sh <= frac_bcd;
                        r_acc     <= '0;
                        r_f       <= '0;
                        r_q       <= '0;
                        r_ovf_st  <= 1'b0;
                        r_derr_st <= 1'b0;
                    end
                end
                S_INT_ACC: begin
                    r_int_sh <= r_int_sh << 4;
                    if (w_acc_ovf) begin
                        r_acc    <= {4'b0000, {INT_BITS{1'b1}}};
                        r_ovf_st <= 1'b1;
                    end else begin
                        r_acc <= w_acc_next;
                    end
                    if (w_dig_int > 4'd9) r_derr_st <= 1'b1;
                end
                S_FRAC_ACC: begin
                    r_frac_sh <= r_frac_sh << 4;
                    r_f       <= w_f_next;
                    r_rem     <= {1'b0, w_f_next};
                    if (w_dig_frac > 4'd9) r_derr_st <= 1'b1;
                end
                S_DIV: begin
                    r_rem <= w_rem_next;
                    r_q   <= (r_q << 1) | FRAC_BITS'(w_ge);
                    if (r_cnt == C_DIV_LAST) begin
                        r_out_valid <= 1'b1;
                        r_out_num   <= w_res_num;
                        r_digit_err <= r_derr_st;
                        r_ovf       <= w_res_ovf;
                    end
                end
                S_DONE: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_to_fixed_seq.sv
// Self-checking bench: arithmetic reference model + scoreboard compare on every
// valid output cycle, plus directed vectors with hand-computed results.
module tb_bcd_to_fixed_seq;
    typedef struct packed {
        logic [15:0] num;
        logic        derr;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default-parameter pair (ROUND=0 / ROUND=1) sharing one stimulus
    logic       a_in_valid = 1'b0, a_out_ready = 1'b1;
    logic [7:0] a_int = 8'h00, a_frac = 8'h00;
    logic       a_in_ready, a_out_valid, a_derr, a_ovf;
    logic       b_in_ready, b_out_valid, b_derr, b_ovf;
    logic [9:0] a_out_num, b_out_num;
    // Wide instance: 3.3 digits, Q8.6, ROUND=1
    logic        w_in_valid = 1'b0, w_out_ready = 1'b1;
    logic [11:0] w_int = 12'h000, w_frac = 12'h000;
    logic        w_in_ready, w_out_valid, w_derr, w_ovf;
    logic [13:0] w_out_num;

    int n_checks = 0;
    int n_errors = 0;
    res_t qa[$], qb[$], qw[$];

    bcd_to_fixed_seq u_dut_a (.clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .int_bcd(a_int), .frac_bcd(a_frac), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_num(a_out_num), .digit_err(a_derr), .ovf(a_ovf));
    bcd_to_fixed_seq #(.ROUND(1)) u_dut_b (.clk(clk), .rst(rst), .in_valid(a_in_valid),
        .in_ready(b_in_ready), .int_bcd(a_int), .frac_bcd(a_frac), .out_valid(b_out_valid),
        .out_ready(a_out_ready), .out_num(b_out_num), .digit_err(b_derr), .ovf(b_ovf));
    bcd_to_fixed_seq #(.INT_DIGITS(3), .FRAC_DIGITS(3), .INT_BITS(8), .FRAC_BITS(6), .ROUND(1))
        u_dut_w (.clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .int_bcd(w_int), .frac_bcd(w_frac), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_num(w_out_num), .digit_err(w_derr), .ovf(w_ovf));

    // Value-level reference: decimal value, exact fraction scaling, range test.
    function automatic res_t model(input int ni, input int nf, input int ib, input int fb,
                                   input int rnd, input longint unsigned ibcd,
                                   input longint unsigned fbcd);
        longint unsigned iv, fv, den, d, q2, v, lim;
        res_t r;
        iv = 0; fv = 0; den = 1;
        r = '0;
        for (int i = ni - 1; i >= 0; i--) begin
            d = (ibcd >> (4 * i)) & 64'hF;
            if (d > 9) r.derr = 1'b1;
            iv = iv * 10 + d;
        end
        for (int i = nf - 1; i >= 0; i--) begin
            d = (fbcd >> (4 * i)) & 64'hF;
            if (d > 9) r.derr = 1'b1;
            fv = fv * 10 + d;
            den = den * 10;
        end
        lim = 64'd1 << (ib + fb);
        if (!r.derr) begin
            if (iv >= (64'd1 << ib)) begin
                r.num = 16'(lim - 1);
                r.ovf = 1'b1;
            end else begin
                q2 = (fv << (fb + 1)) / den;
                v  = (iv << fb) + (q2 >> 1) + ((rnd != 0) ? (q2 & 64'd1) : 64'd0);
                if (v >= lim) begin
                    r.num = 16'(lim - 1);
                    r.ovf = 1'b1;
                end else begin
                    r.num = 16'(v);
                end
            end
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_stream(input string nm, input int qsize, input res_t e,
                              input logic [15:0] num, input logic derr, input logic ov);
        if (qsize == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: out_valid with no pending conversion (num %0h)", nm, num);
        end else begin
            chk({nm, "_num"}, 32'(num), 32'(e.num));
            chk({nm, "_derr"}, 32'(derr), 32'(e.derr));
            chk({nm, "_ovf"}, 32'(ov), 32'(e.ovf));
        end
    endtask

    task automatic wait_out_a(input string nm, output int n);
        n = 0;
        while (!a_out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'd11);
    endtask

    task automatic run_a(input string nm, input logic [7:0] iv, input logic [7:0] fv,
                         input logic [9:0] ea, input logic [9:0] eb,
                         input logic ed, input logic eo);
        int n;
        @(negedge clk);
        chk({nm, "_in_ready"}, 32'(a_in_ready), 32'd1);
        a_int = iv; a_frac = fv; a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0; a_int = 8'hFF; a_frac = 8'hFF;
        wait_out_a(nm, n);
        chk({nm, "_num_r0"}, 32'(a_out_num), 32'(ea));
        chk({nm, "_num_r1"}, 32'(b_out_num), 32'(eb));
        chk({nm, "_derr"}, 32'(a_derr), 32'(ed));
        chk({nm, "_ovf"}, 32'(a_ovf), 32'(eo));
        @(negedge clk);
        chk({nm, "_valid_drop"}, 32'(a_out_valid), 32'd0);
    endtask

    task automatic run_w(input string nm, input logic [11:0] iv, input logic [11:0] fv,
                         input logic [13:0] en, input logic eo);
        int n;
        @(negedge clk);
        w_int = iv; w_frac = fv; w_in_valid = 1'b1;
        @(negedge clk);
        w_in_valid = 1'b0; w_int = 12'hFFF; w_frac = 12'hFFF;
        n = 0;
        while (!w_out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'd13);
        chk({nm, "_num"}, 32'(w_out_num), 32'(en));
        chk({nm, "_ovf"}, 32'(w_ovf), 32'(eo));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        fork
            forever begin
                @(posedge clk);
                if (rst) begin
                    qa.delete(); qb.delete(); qw.delete();
                end else begin
                    if (a_out_valid && a_out_ready && qa.size() > 0) void'(qa.pop_front());
                    if (b_out_valid && a_out_ready && qb.size() > 0) void'(qb.pop_front());
                    if (w_out_valid && w_out_ready && qw.size() > 0) void'(qw.pop_front());
                    if (a_in_valid && a_in_ready) qa.push_back(model(2, 2, 4, 6, 0, 64'(a_int), 64'(a_frac)));
                    if (a_in_valid && b_in_ready) qb.push_back(model(2, 2, 4, 6, 1, 64'(a_int), 64'(a_frac)));
                    if (w_in_valid && w_in_ready) qw.push_back(model(3, 3, 8, 6, 1, 64'(w_int), 64'(w_frac)));
                end
            end
            forever begin
                @(negedge clk);
                if (a_out_valid) chk_stream("stream_a", qa.size(), (qa.size() > 0) ? qa[0] : '0, 16'(a_out_num), a_derr, a_ovf);
                if (b_out_valid) chk_stream("stream_b", qb.size(), (qb.size() > 0) ? qb[0] : '0, 16'(b_out_num), b_derr, b_ovf);
                if (w_out_valid) chk_stream("stream_w", qw.size(), (qw.size() > 0) ? qw[0] : '0, 16'(w_out_num), w_derr, w_ovf);
            end
        join_none

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_num", 32'(a_out_num), 32'd0);
        chk("rst_in_ready", 32'(a_in_ready), 32'd0);
        chk("rst_w_in_ready", 32'(w_in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("release_in_ready", 32'(a_in_ready), 32'd1);

        run_a("t3p75",  8'h03, 8'h75, 10'h0F0, 10'h0F0, 1'b0, 1'b0);
        run_a("t1p01",  8'h01, 8'h01, 10'h040, 10'h041, 1'b0, 1'b0);
        run_a("t17p5",  8'h17, 8'h50, 10'h3FF, 10'h3FF, 1'b0, 1'b1);
        run_a("t15p5",  8'h15, 8'h50, 10'h3E0, 10'h3E0, 1'b0, 1'b0);
        run_a("tderrf", 8'h00, 8'hA0, 10'h000, 10'h000, 1'b1, 1'b0);
        run_a("tderri", 8'h1B, 8'h00, 10'h000, 10'h000, 1'b1, 1'b0);
        run_a("t9p99",  8'h09, 8'h99, 10'h27F, 10'h27F, 1'b0, 1'b0);
        run_a("t15p99", 8'h15, 8'h99, 10'h3FF, 10'h3FF, 1'b0, 1'b0);
        run_a("tzero",  8'h00, 8'h00, 10'h000, 10'h000, 1'b0, 1'b0);
        run_w("w2p999",   12'h002, 12'h999, 14'h00C0, 1'b0);
        run_w("w255p999", 12'h255, 12'h999, 14'h3FFF, 1'b1);
        run_w("w99p5",    12'h099, 12'h500, 14'h18E0, 1'b0);

        // Back-pressure: result held, new input ignored while DONE
        @(negedge clk);
        a_out_ready = 1'b0; a_int = 8'h03; a_frac = 8'h75; a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        wait_out_a("hold", n);
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", 32'(a_out_valid), 32'd1);
            chk("hold_num", 32'(a_out_num), 32'h0F0);
            chk("hold_in_ready", 32'(a_in_ready), 32'd0);
            a_in_valid = 1'b1; a_int = 8'h01; a_frac = 8'h01;
            @(negedge clk);
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        @(negedge clk);
        chk("hold_release_valid", 32'(a_out_valid), 32'd0);
        chk("hold_release_in_ready", 32'(a_in_ready), 32'd1);

        // Reset while a result is waiting in DONE
        a_out_ready = 1'b0; a_int = 8'h15; a_frac = 8'h50; a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        wait_out_a("rstdone", n);
        #2 rst = 1'b1;
        #1;
        chk("rstdone_valid", 32'(a_out_valid), 32'd0);
        chk("rstdone_num", 32'(a_out_num), 32'd0);
        chk("rstdone_in_ready", 32'(a_in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0; a_out_ready = 1'b1;
        @(negedge clk);
        chk("rstdone_in_ready_after", 32'(a_in_ready), 32'd1);

        // Reset in the middle of the division phase
        a_int = 8'h09; a_frac = 8'h99; a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rstdiv_valid", 32'(a_out_valid), 32'd0);
        chk("rstdiv_in_ready", 32'(a_in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstdiv_in_ready_after", 32'(a_in_ready), 32'd1);
        run_a("post_rst", 8'h03, 8'h75, 10'h0F0, 10'h0F0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
